// File: rtl/shift_add_multiplier.sv
// 32x32 unsigned sequential multiplier: one shift-add step per clock for 32 clocks.
// All accumulation goes through an external 32-bit adder driven by add_a/add_b/add_cin.
module shift_add_multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_c,
    input  logic        add_cout,
    output logic [1:0]  dbg_state_o
);

    // Handshake: start is a request taken only in IDLE (ignored otherwise, no
    // backpressure); done is a one-cycle valid strobe qualifying product.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [31:0] m_q,       m_d;
    logic [31:0] acc_hi_q,  acc_hi_d;
    logic [31:0] acc_lo_q,  acc_lo_d;
    logic [5:0]  count_q,   count_d;
    logic [63:0] product_q, product_d;
    logic [63:0] step_acc;

    // Adder sum joined with its carry, then the whole 65-bit value shifted right by one.
    assign step_acc = {add_cout, add_c, acc_lo_q[31:1]};

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d      = a;
                    acc_hi_d = 32'd0;
                    acc_lo_d = b;
                    count_d  = 6'd0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_hi_d = step_acc[63:32];
                acc_lo_d = step_acc[31:0];
                count_d  = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    product_d = step_acc;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= 32'd0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            count_q   <= 6'd0;
            product_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Outputs come only from registers, so start/a/b never reach them combinationally.
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign product     = product_q;
    assign add_a       = busy ? acc_hi_q : 32'd0;
    assign add_b       = (busy && acc_lo_q[0]) ? m_q : 32'd0;
    assign add_cin     = 1'b0;
    assign dbg_state_o = state_q;

endmodule
